// File: rtl/sp_ram_master.sv
// Single-port RAM initiator: sequences cs/wr_e/oe strobes for valid/ready read and write commands.
// Optional power-up clear sweep is enabled by defining SP_RAM_MASTER_INIT_EN.
module sp_ram_master #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 7,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_wr,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_rdata,
  output logic          o_busy,
  output logic          o_ram_cs,
  output logic          o_ram_wr_e,
  output logic          o_ram_oe,
  output logic [AW-1:0] o_ram_address,
  inout  wire  [DW-1:0] io_ram_data
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StTurn, StInit} state_e;

  localparam logic [2:0] RdCntInit = 3'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic [2:0]    rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          cs_q, cs_d, wr_e_q, wr_e_d, oe_q, oe_d, drive_q, drive_d;
  logic          rsp_valid_q, rsp_valid_d, ready_q, ready_d, busy_q, busy_d;

`ifdef SP_RAM_MASTER_INIT_EN
  localparam logic [AW:0] SweepEnd = (AW+1)'(DEPTH);
  logic [AW:0] sweep_q, sweep_d;
`endif

  // Outputs are computed one cycle ahead so every strobe comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cs_d        = 1'b0;
    wr_e_d      = 1'b0;
    oe_d        = 1'b0;
    drive_d     = 1'b0;
    rsp_valid_d = 1'b0;
    ready_d     = 1'b0;
    busy_d      = 1'b1;
`ifdef SP_RAM_MASTER_INIT_EN
    sweep_d     = sweep_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_req_valid && ready_q) begin
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          cs_d    = 1'b1;
          if (i_req_wr) begin
            state_d = StWrite;
            wr_e_d  = 1'b1;
            drive_d = 1'b1;
          end else begin
            state_d  = StRead;
            oe_d     = 1'b1;
            rd_cnt_d = RdCntInit;
          end
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      StWrite, StTurn: begin
        state_d = StIdle;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      StRead: begin
        if (rd_cnt_q == 3'd0) begin
          rdata_d     = io_ram_data;
          rsp_valid_d = 1'b1;
          state_d     = StTurn;
        end else begin
          rd_cnt_d = rd_cnt_q - 3'd1;
          cs_d     = 1'b1;
          oe_d     = 1'b1;
        end
      end
`ifdef SP_RAM_MASTER_INIT_EN
      StInit: begin
        if (sweep_q == SweepEnd) begin
          state_d = StIdle;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cs_d    = 1'b1;
          wr_e_d  = 1'b1;
          drive_d = 1'b1;
          addr_d  = sweep_q[AW-1:0];
          wdata_d = '0;
          sweep_d = sweep_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
`ifdef SP_RAM_MASTER_INIT_EN
      state_q <= StInit;
      sweep_q <= '0;
`else
      state_q <= StIdle;
`endif
      rd_cnt_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cs_q        <= 1'b0;
      wr_e_q      <= 1'b0;
      oe_q        <= 1'b0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
`ifdef SP_RAM_MASTER_INIT_EN
      sweep_q <= sweep_d;
`endif
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cs_q        <= cs_d;
      wr_e_q      <= wr_e_d;
      oe_q        <= oe_d;
      drive_q     <= drive_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign io_ram_data   = drive_q ? wdata_q : {DW{1'bz}};
  assign o_req_ready   = ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rdata_q;
  assign o_busy        = busy_q;
  assign o_ram_cs      = cs_q;
  assign o_ram_wr_e    = wr_e_q;
  assign o_ram_oe      = oe_q;
  assign o_ram_address = addr_q;

endmodule

// File: tb/tb_sp_ram_master.sv
// Bench for sp_ram_master: behavioural RAM with a bus keeper on the shared data line, and a
// reference memory model updated per accepted command. Handles SP_RAM_MASTER_INIT_EN builds too.
module tb_sp_ram_master;

  localparam int unsigned DW = 8, AW = 7, DEPTH = 128, RdLat = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, busy, ram_cs, ram_wr_e, ram_oe;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_address;
  wire  [DW-1:0] ram_data;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int            n_cmp = 0, n_bad = 0, bus_err = 0, cyc = 0;
  bit            mon_en = 1'b0;

  sp_ram_master #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RdLat)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_busy(busy),
    .o_ram_cs(ram_cs), .o_ram_wr_e(ram_wr_e), .o_ram_oe(ram_oe),
    .o_ram_address(ram_address), .io_ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // RAM drives on reads; a keeper holds 0 whenever nobody should drive, so a stray
  // master drive shows up as a nonzero (or conflicting) value.
  assign ram_data = (ram_cs && ram_oe && !ram_wr_e) ? mem[ram_address] :
                    (ram_cs && ram_wr_e) ? {DW{1'bz}} : {DW{1'b0}};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_cs && ram_wr_e && !ram_oe) mem[ram_address] <= ram_data;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_cs && ram_wr_e && ram_oe) bus_err <= bus_err + 1;
      else if (ram_cs && ram_oe) begin
        if (ram_data !== mem[ram_address]) bus_err <= bus_err + 1;
      end else if (!(ram_cs && ram_wr_e)) begin
        if (ram_data !== {DW{1'b0}}) bus_err <= bus_err + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 50) begin
      step();
      k++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready: o_req_ready=%0b, required 1 within 50 cycles", req_ready);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    ref_mem[a] = d;
    n_cmp++;
    if ({ram_cs, ram_wr_e, ram_oe, req_ready, busy} !== 5'b11001 || ram_address !== a ||
        ram_data !== d) begin
      n_bad++;
      $display("FAIL write_cycle: cs/we/oe/rdy/busy=%b addr=%h data=%h, required 11001 %h %h",
               {ram_cs, ram_wr_e, ram_oe, req_ready, busy}, ram_address, ram_data, a, d);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_wdata = DW'($urandom);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < RdLat; k++) begin
      n_cmp++;
      if ({ram_cs, ram_wr_e, ram_oe, rsp_valid, req_ready} !== 5'b10100 || ram_address !== a) begin
        n_bad++;
        $display("FAIL read_strobe[%0d]: cs/we/oe/rv/rdy=%b addr=%h, required 10100 %h", k,
                 {ram_cs, ram_wr_e, ram_oe, rsp_valid, req_ready}, ram_address, a);
      end
      step();
    end
    n_cmp++;
    if ({ram_cs, ram_wr_e, ram_oe, rsp_valid, req_ready} !== 5'b00010 ||
        rsp_rdata !== ref_mem[a]) begin
      n_bad++;
      $display("FAIL read_rsp @%h: cs/we/oe/rv/rdy=%b rdata=%h, required 00010 %h", a,
               {ram_cs, ram_wr_e, ram_oe, rsp_valid, req_ready}, rsp_rdata, ref_mem[a]);
    end
    step();
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== ref_mem[a]) begin
      n_bad++;
      $display("FAIL read_done @%h: rv=%b rdy=%b rdata=%h, required 0 1 %h", a, rsp_valid,
               req_ready, rsp_rdata, ref_mem[a]);
    end
  endtask

`ifdef SP_RAM_MASTER_INIT_EN
  task automatic test_init_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      step();
      n_cmp++;
      if ({ram_cs, ram_wr_e, ram_oe, req_ready, busy, rsp_valid} !== 6'b110010 ||
          ram_address !== AW'(i) || ram_data !== {DW{1'b0}}) begin
        n_bad++;
        $display("FAIL init_sweep[%0d]: cs/we/oe/rdy/busy/rv=%b addr=%h data=%h, required 110010 %h 00",
                 i, {ram_cs, ram_wr_e, ram_oe, req_ready, busy, rsp_valid}, ram_address, ram_data,
                 AW'(i));
      end
    end
    step();
    n_cmp++;
    if ({ram_cs, req_ready, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL init_done: cs/rdy/busy=%b, required 010", {ram_cs, req_ready, busy});
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask
`endif

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({ram_cs, ram_wr_e, ram_oe, rsp_valid, busy, req_ready} !== 6'b0 || ram_address !== '0 ||
        rsp_rdata !== '0 || ram_data !== {DW{1'b0}}) begin
      n_bad++;
      $display("FAIL reset_state: strobes/rv/busy/rdy=%b addr=%h rdata=%h bus=%h, required all 0",
               {ram_cs, ram_wr_e, ram_oe, rsp_valid, busy, req_ready}, ram_address, rsp_rdata,
               ram_data);
    end
    req_valid = 1'b0;
    mon_en = 1'b1;
    rst_n = 1'b1;
`ifdef SP_RAM_MASTER_INIT_EN
    test_init_sweep();
`else
    step();
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || ram_cs !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b cs=%b, required 1 0 0", req_ready, busy,
               ram_cs);
    end
`endif
  endtask

  task automatic test_basic();
    do_write(7'h05, 8'hA5);
    step();
    n_cmp++;
    if (req_ready !== 1'b1 || ram_cs !== 1'b0 || mem[5] !== 8'hA5) begin
      n_bad++;
      $display("FAIL write_done: rdy=%b cs=%b ram[5]=%h, required 1 0 a5", req_ready, ram_cs,
               mem[5]);
    end
    do_read(7'h05);
  endtask

  task automatic test_back_to_back();
    int c0;
    do_write(7'h10, DW'($urandom));
    c0 = cyc;
    do_write(7'h11, DW'($urandom));
    n_cmp++;
    if (cyc - c0 !== 2) begin
      n_bad++;
      $display("FAIL back_to_back: accept spacing=%0d cycles, required 2", cyc - c0);
    end
    do_read(7'h10);
    do_read(7'h11);
  endtask

  task automatic test_random();
    for (int a = 0; a < DEPTH - 1; a++) do_write(AW'(a), DW'($urandom));
    for (int a = 0; a < DEPTH - 1; a++) do_read(AW'(a));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) do_write(AW'($urandom_range(DEPTH - 1, 0)), DW'($urandom));
      else do_read(AW'($urandom_range(DEPTH - 1, 0)));
    end
  endtask

  task automatic test_read_then_write();
    logic [AW-1:0] a, b;
    logic [DW-1:0] d;
    a = AW'($urandom_range(63, 0));
    b = AW'($urandom_range(127, 64));
    d = DW'($urandom_range(255, 1));
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    step();
    req_wr = 1'b1; req_addr = b; req_wdata = d;
    for (int k = 0; k < RdLat; k++) begin
      n_cmp++;
      if ({ram_cs, ram_wr_e, ram_oe, req_ready} !== 4'b1010 || ram_address !== a) begin
        n_bad++;
        $display("FAIL rtw_read[%0d]: cs/we/oe/rdy=%b addr=%h, required 1010 %h", k,
                 {ram_cs, ram_wr_e, ram_oe, req_ready}, ram_address, a);
      end
      step();
    end
    n_cmp++;
    if ({ram_cs, ram_wr_e, ram_oe, rsp_valid, req_ready} !== 5'b00010 ||
        ram_data !== {DW{1'b0}} || rsp_rdata !== ref_mem[a]) begin
      n_bad++;
      $display("FAIL rtw_turn: cs/we/oe/rv/rdy=%b bus=%h rdata=%h, required 00010 00 %h",
               {ram_cs, ram_wr_e, ram_oe, rsp_valid, req_ready}, ram_data, rsp_rdata, ref_mem[a]);
    end
    step();
    n_cmp++;
    if ({ram_cs, req_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL rtw_idle: cs/rdy=%b, required 01", {ram_cs, req_ready});
    end
    step();
    req_valid = 1'b0;
    ref_mem[b] = d;
    n_cmp++;
    if ({ram_cs, ram_wr_e, ram_oe} !== 3'b110 || ram_address !== b || ram_data !== d) begin
      n_bad++;
      $display("FAIL rtw_write: cs/we/oe=%b addr=%h data=%h, required 110 %h %h",
               {ram_cs, ram_wr_e, ram_oe}, ram_address, ram_data, b, d);
    end
    do_read(b);
  endtask

  task automatic test_reset_mid_read();
    int seen = 0;
    do_write(7'h09, 8'h5A);
    do_read(7'h09);
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 7'h09;
    step();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({ram_cs, ram_wr_e, ram_oe, rsp_valid, req_ready, busy} !== 6'b0 ||
        rsp_rdata !== '0 || ram_data !== {DW{1'b0}}) begin
      n_bad++;
      $display("FAIL reset_mid_read: strobes/rv/rdy/busy=%b rdata=%h bus=%h, required all 0",
               {ram_cs, ram_wr_e, ram_oe, rsp_valid, req_ready, busy}, rsp_rdata, ram_data);
    end
    rst_n = 1'b1;
`ifdef SP_RAM_MASTER_INIT_EN
    test_init_sweep();
`else
    for (int k = 0; k < RdLat + 2; k++) begin
      step();
      if (rsp_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL dropped_read: rsp_valid pulses after reset=%0d, required 0", seen);
    end
`endif
    do_read(7'h09);
  endtask

  task automatic test_bus_clean();
    step();
    n_cmp++;
    if (bus_err !== 0) begin
      n_bad++;
      $display("FAIL bus_clean: contention/stray-drive cycles=%0d, required 0", bus_err);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'($urandom_range(255, 1));
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_read_then_write();
    test_reset_mid_read();
    test_bus_clean();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
